// File: rtl/bcd_freq_meter.sv
`default_nettype none
// ============================================================================
// bcd_freq_meter : counts sig_in rising edges per GATE_CYCLES window, packed BCD
// Revision       : 1.0
// ============================================================================
module bcd_freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int DIGITS      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sig_in,
  input  logic                hold,
  output logic [4*DIGITS-1:0] bcd_cnt,
  output logic                cnt_valid,
  output logic                overflow
);

  localparam int                   c_timer_w    = $clog2(GATE_CYCLES);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(GATE_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_edge_d;
  logic                 r_pulse;
  logic [c_timer_w-1:0] r_timer;
  logic [4*DIGITS-1:0]  r_work;
  logic                 r_sticky;

  logic [DIGITS:0]      w_carry;
  logic [4*DIGITS-1:0]  w_inc;
  logic [4*DIGITS-1:0]  w_next_work;
  logic                 w_sat;
  logic                 w_next_sticky;
  logic                 w_term;

  assign w_carry[0] = r_pulse;

  // Single-cycle ripple carry across all digits.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] w_d;
      assign w_d                = r_work[4*g +: 4];
      assign w_inc[4*g +: 4]    = !w_carry[g] ? w_d :
                                  (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
      assign w_carry[g+1]       = w_carry[g] && (w_d == 4'd9);
    end
  endgenerate

  // A carry out of the top digit means all nines: hold there and flag it.
  assign w_sat         = w_carry[DIGITS];
  assign w_next_work   = w_sat ? r_work : w_inc;
  assign w_next_sticky = r_sticky | w_sat;
  assign w_term        = (r_timer == c_timer_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_edge_d  <= 1'b0;
      r_pulse   <= 1'b0;
      r_timer   <= '0;
      r_work    <= '0;
      r_sticky  <= 1'b0;
      bcd_cnt   <= '0;
      cnt_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      r_sync1   <= sig_in;
      r_sync2   <= r_sync1;
      r_edge_d  <= r_sync2;
      r_pulse   <= r_sync2 & ~r_edge_d;
      cnt_valid <= 1'b0;
      if (w_term) begin
        // Increment due in the terminal cycle belongs to the closing window.
        r_timer  <= '0;
        r_work   <= '0;
        r_sticky <= 1'b0;
        if (!hold) begin
          bcd_cnt   <= w_next_work;
          overflow  <= w_next_sticky;
          cnt_valid <= 1'b1;
        end
      end else begin
        r_timer  <= r_timer + c_timer_w'(1);
        r_work   <= w_next_work;
        r_sticky <= w_next_sticky;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_freq_meter.sv
`default_nettype none
// ============================================================================
// tb_bcd_freq_meter : two meter instances against an edge-counting reference
// Revision          : 1.0
// ============================================================================
module tb_bcd_freq_meter;

  localparam int c_gate_a = 100;
  localparam int c_gate_b = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig_in = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] bcd_a;
  logic        valid_a, ovf_a;
  logic [7:0]  bcd_b;
  logic        valid_b, ovf_b;

  int checks = 0;
  int failures = 0;
  int per = 1, hi = 0, ph = 0;
  bit rnd_mode = 0;

  always #5 clk = ~clk;

  bcd_freq_meter #(.GATE_CYCLES(c_gate_a), .DIGITS(8)) dut_a (
    .clk(clk), .reset(reset), .sig_in(sig_in), .hold(hold),
    .bcd_cnt(bcd_a), .cnt_valid(valid_a), .overflow(ovf_a));

  bcd_freq_meter #(.GATE_CYCLES(c_gate_b), .DIGITS(2)) dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_in), .hold(hold),
    .bcd_cnt(bcd_b), .cnt_valid(valid_b), .overflow(ovf_b));

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: clock-edge index e, each rising sample at edge n credited to
  // window ceil((n+3)/G); windows close on edges that are multiples of G.
  for (genvar k = 0; k < 2; k++) begin : g_model
    localparam int G    = (k == 0) ? c_gate_a : c_gate_b;
    localparam int MAXC = (k == 0) ? 99_999_999 : 99;
    int          e;
    logic        prev;
    int          win [0:255];
    logic [31:0] exp_bcd;
    logic        exp_valid;
    logic        exp_ovf;

    always @(posedge clk or posedge reset) begin : p_model
      int ne, idx, m, c;
      if (reset) begin
        e         <= 0;
        prev      <= 1'b0;
        exp_bcd   <= '0;
        exp_valid <= 1'b0;
        exp_ovf   <= 1'b0;
        for (int i = 0; i < 256; i++) win[i] <= 0;
      end else begin
        ne = e + 1;
        e         <= ne;
        prev      <= sig_in;
        exp_valid <= 1'b0;
        if (sig_in && !prev) begin
          idx = ((ne + 3 + G - 1) / G) % 256;
          win[idx] <= win[idx] + 1;
        end
        if (ne % G == 0) begin
          m = (ne / G) % 256;
          c = win[m];
          win[m] <= 0;
          if (!hold) begin
            exp_valid <= 1'b1;
            exp_bcd   <= to_bcd((c > MAXC) ? MAXC : c);
            exp_ovf   <= (c > MAXC);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_bcd",   bcd_a,            g_model[0].exp_bcd);
    chk("a_valid", {31'b0, valid_a}, {31'b0, g_model[0].exp_valid});
    chk("a_ovf",   {31'b0, ovf_a},   {31'b0, g_model[0].exp_ovf});
    chk("b_bcd",   {24'b0, bcd_b},   g_model[1].exp_bcd);
    chk("b_valid", {31'b0, valid_b}, {31'b0, g_model[1].exp_valid});
    chk("b_ovf",   {31'b0, ovf_b},   {31'b0, g_model[1].exp_ovf});
  endtask

  task automatic set_wave(input int p, input int h);
    per = p;
    hi = h;
    ph = 0;
    rnd_mode = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rnd_mode) sig_in = 1'($urandom_range(0, 1));
      else begin
        sig_in = (ph < hi);
        ph = (ph + 1) % per;
      end
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  task automatic align_a(input int phase);
    for (int k = 0; k < 200 && (g_model[0].e % c_gate_a) != phase; k++) run(1);
    chk("align", 32'(g_model[0].e % c_gate_a), 32'(phase));
  endtask

  initial begin
    // Reset state
    run(3);
    chk("rst_a_bcd",   bcd_a, 32'h0);
    chk("rst_a_valid", {31'b0, valid_a}, 32'h0);
    chk("rst_b_ovf",   {31'b0, ovf_b}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Period 10, then period 4, then period 2 (saturates the 2-digit meter)
    set_wave(10, 5); run(350);
    chk("p10_a", bcd_a, 32'h00000010);
    set_wave(4, 2);  run(300);
    chk("p4_a", bcd_a, 32'h00000025);
    set_wave(2, 1);  run(500);
    chk("p2_a", bcd_a, 32'h00000050);
    chk("p2_b_sat", {24'b0, bcd_b}, 32'h99);
    chk("p2_b_ovf", {31'b0, ovf_b}, 32'h1);

    // Hold across terminal cycles, then release with a new rate
    hold = 1'b1;
    set_wave(10, 5); run(150);
    chk("hold_a", bcd_a, 32'h00000050);
    hold = 1'b0;
    set_wave(5, 2);  run(250);
    chk("p5_a", bcd_a, 32'h00000020);
    set_wave(20, 10); run(450);
    chk("p20_b", {24'b0, bcd_b}, 32'h10);
    chk("p20_b_ovf", {31'b0, ovf_b}, 32'h0);

    // Randomised traffic: per-cycle noise, then random period/duty/hold segments
    rnd_mode = 1; run(400);
    for (int s = 0; s < 6; s++) begin
      int p;
      p = int'($urandom_range(2, 15));
      set_wave(p, int'($urandom_range(1, p - 1)));
      hold = ($urandom_range(0, 3) == 0);
      run(int'($urandom_range(150, 300)));
    end
    hold = 1'b0;

    // Reset mid-window
    set_wave(10, 5); run(250);
    align_a(50);
    chk("pre_rst_a", bcd_a, 32'h00000010);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_a_bcd", bcd_a, 32'h0);
    chk("arst_b_bcd", {24'b0, bcd_b}, 32'h0);
    chk("arst_a_ovf", {31'b0, ovf_a}, 32'h0);
    run(2);
    @(negedge clk);
    reset = 1'b0;
    run(250);
    chk("post_rst_a", {31'b0, (bcd_a == 32'h10) || (bcd_a == 32'h11)}, 32'h1);

    // Idle input, then a single pulse sampled two edges before a terminal edge
    set_wave(1, 0); run(300);
    chk("idle_a", bcd_a, 32'h0);
    align_a(97);
    set_wave(1, 1); run(1);
    set_wave(1, 0); run(2);
    chk("late_pulse_excl", bcd_a, 32'h0);
    chk("late_pulse_valid", {31'b0, valid_a}, 32'h1);
    run(100);
    chk("late_pulse_next", bcd_a, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
